// File: rtl/lsu_axi_master.sv
// lsu_axi_master
//   AXI4-Lite load/store unit sitting between the execute stage and the data
//   memory / crossbar. Handles one access at a time: loads use AR/R, stores
//   use AW/W/B. Sub-word loads are aligned and sign/zero extended; sub-word
//   stores get shifted data and a byte strobe. Each channel's valid/ready
//   output is held off by a programmable delay so slaves can be stressed.
//   Misaligned accesses (and size D on a 32-bit bus) complete with resp_err_o
//   without touching the bus; a non-OKAY xRESP also sets resp_err_o.
//
//   Optional build macro: LSU_LFSR_DELAY_EN
//     defined   -> each delay counter loads (LFSR[3:0] & delay parameter),
//                  LFSR x^16+x^14+x^13+x^11, seed 16'hACE1, advances every cycle
//     undefined -> delay counters load the parameters directly
//
// Ports
//   clk_i, rst_ni                clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o    request handshake (ready only when idle)
//   req_wen_i                    1 = store, 0 = load
//   req_size_i                   0=B 1=H 2=W 3=D
//   req_unsigned_i               loads: zero-extend
//   req_addr_i, req_wdata_i      byte address, LSB-aligned store data
//   resp_valid_o                 one-cycle completion pulse
//   resp_rdata_o                 extended load data, 0 for stores/errors
//   resp_err_o                   misaligned or xRESP != OKAY
//   m_ar*/m_r*, m_aw*/m_w*/m_b*  AXI4-Lite master channels
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready_o high
// S_AR   | delay then ARVALID until AR handshake
// S_R    | delay then RREADY until R handshake
// S_AW   | delay then AWVALID/WVALID until both handshakes done
// S_B    | delay then BREADY until B handshake
// S_RESP | resp_valid_o pulse
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int AR_DLY = 3,
  parameter int R_DLY  = 7,
  parameter int AW_DLY = 3,
  parameter int B_DLY  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic [ADDR_W-1:0]   m_araddr_o,
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic [1:0]          m_rresp_i,
  input  logic                m_rvalid_i,
  output logic                m_rready_o,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  input  logic [1:0]          m_bresp_i,
  input  logic                m_bvalid_i,
  output logic                m_bready_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  localparam logic [7:0] AR_DLY_C = 8'(AR_DLY);
  localparam logic [7:0] R_DLY_C  = 8'(R_DLY);
  localparam logic [7:0] AW_DLY_C = 8'(AW_DLY);
  localparam logic [7:0] B_DLY_C  = 8'(B_DLY);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic [7:0]        dly_mask;
  logic              misaligned;
  logic              aw_hs, w_hs;
  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  sh_amt;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ld_mask;
  logic              ld_sign;
  logic [DATA_W-1:0] ld_data;
  logic [STRB_W-1:0] strb_base;

`ifdef LSU_LFSR_DELAY_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
  end

  assign dly_mask = {4'h0, lfsr_q[3:0]};
`else
  assign dly_mask = 8'hFF;
`endif

  // Size D only exists on a 64-bit bus; on a 32-bit bus it is reported like a misalignment.
  always_comb begin
    misaligned = 1'b0;
    case (req_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr_i[0];
      2'd2:    misaligned = |req_addr_i[1:0];
      default: misaligned = (DATA_W != 64) || (|req_addr_i[2:0]);
    endcase
  end

  assign off    = addr_q[OFF_W-1:0];
  assign sh_amt = {off, 3'b000};

  assign req_ready_o  = (state_q == S_IDLE);
  assign m_arvalid_o  = (state_q == S_AR) && (cnt_q == 8'd0);
  assign m_rready_o   = (state_q == S_R)  && (cnt_q == 8'd0);
  assign m_awvalid_o  = (state_q == S_AW) && (cnt_q == 8'd0) && !aw_done_q;
  assign m_wvalid_o   = (state_q == S_AW) && (cnt_q == 8'd0) && !w_done_q;
  assign m_bready_o   = (state_q == S_B)  && (cnt_q == 8'd0);
  assign aw_hs        = m_awvalid_o && m_awready_i;
  assign w_hs         = m_wvalid_o && m_wready_i;

  assign m_araddr_o   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign m_awaddr_o   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign m_wdata_o    = wdata_q << sh_amt;

  always_comb begin
    strb_base = '0;
    case (size_q)
      2'd0:    strb_base = STRB_W'(8'h01);
      2'd1:    strb_base = STRB_W'(8'h03);
      2'd2:    strb_base = STRB_W'(8'h0F);
      default: strb_base = STRB_W'(8'hFF);
    endcase
  end

  assign m_wstrb_o = strb_base << off;

  assign rd_shift = rdata_q >> sh_amt;

  always_comb begin
    ld_mask = '0;
    ld_sign = 1'b0;
    case (size_q)
      2'd0: begin
        ld_mask = DATA_W'(8'hFF);
        ld_sign = rd_shift[7];
      end
      2'd1: begin
        ld_mask = DATA_W'(16'hFFFF);
        ld_sign = rd_shift[15];
      end
      2'd2: begin
        ld_mask = DATA_W'(32'hFFFF_FFFF);
        ld_sign = rd_shift[31];
      end
      default: begin
        ld_mask = '1;
        ld_sign = 1'b0;
      end
    endcase
  end

  assign ld_data = (rd_shift & ld_mask) | ((ld_sign && !unsigned_q) ? ~ld_mask : '0);

  assign resp_valid_o = (state_q == S_RESP);
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rdata_o = (resp_valid_o && !err_q && !wen_q) ? ld_data : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          wen_d      = req_wen_i;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          err_d      = misaligned;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if (misaligned) begin
            state_d = S_RESP;
          end else if (req_wen_i) begin
            state_d = S_AW;
            cnt_d   = AW_DLY_C & dly_mask;
          end else begin
            state_d = S_AR;
            cnt_d   = AR_DLY_C & dly_mask;
          end
        end
      end
      S_AR: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        if (m_arvalid_o && m_arready_i) begin
          state_d = S_R;
          cnt_d   = R_DLY_C & dly_mask;
        end
      end
      S_R: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        if (m_rready_o && m_rvalid_i) begin
          rdata_d = m_rdata_i;
          err_d   = |m_rresp_i;
          state_d = S_RESP;
        end
      end
      S_AW: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = S_B;
          cnt_d     = B_DLY_C & dly_mask;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_B: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        if (m_bready_o && m_bvalid_i) begin
          err_d   = |m_bresp_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      wen_q      <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master.
//   u_dut_a: default delays, driven by a configurable AXI4-Lite slave model.
//   u_dut_b: all delays 0, slave that is permanently ready/valid.
// Inputs are driven 1 time unit after the rising edge; monitors sample on
// the falling edge. Cycle indices below are values of cyc at the falling
// edge; the accept cycle is the one in which req_valid && req_ready is seen.
module tb_lsu_axi_master;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  // ---------------- instance A signals ----------------
  logic        a_req_valid, a_req_ready, a_req_wen, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic [31:0] a_araddr, a_awaddr, a_wdata;
  logic        a_arvalid, a_arready, a_rvalid, a_rready;
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic [31:0] a_rdata;
  logic [1:0]  a_rresp, a_bresp;
  logic [3:0]  a_wstrb;

  // ---------------- instance B signals ----------------
  logic        b_req_valid, b_req_ready, b_req_wen, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [31:0] b_araddr, b_awaddr, b_wdata;
  logic        b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready;
  logic [3:0]  b_wstrb;

  lsu_axi_master u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_wen_i(a_req_wen),
    .req_size_i(a_req_size), .req_unsigned_i(a_req_unsigned),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
    .resp_valid_o(a_resp_valid), .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err),
    .m_araddr_o(a_araddr), .m_arvalid_o(a_arvalid), .m_arready_i(a_arready),
    .m_rdata_i(a_rdata), .m_rresp_i(a_rresp), .m_rvalid_i(a_rvalid), .m_rready_o(a_rready),
    .m_awaddr_o(a_awaddr), .m_awvalid_o(a_awvalid), .m_awready_i(a_awready),
    .m_wdata_o(a_wdata), .m_wstrb_o(a_wstrb), .m_wvalid_o(a_wvalid), .m_wready_i(a_wready),
    .m_bresp_i(a_bresp), .m_bvalid_i(a_bvalid), .m_bready_o(a_bready)
  );

  lsu_axi_master #(.AR_DLY(0), .R_DLY(0), .AW_DLY(0), .B_DLY(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_wen_i(b_req_wen),
    .req_size_i(b_req_size), .req_unsigned_i(b_req_unsigned),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .resp_valid_o(b_resp_valid), .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err),
    .m_araddr_o(b_araddr), .m_arvalid_o(b_arvalid), .m_arready_i(1'b1),
    .m_rdata_i(32'hCAFE_F00D), .m_rresp_i(2'b00), .m_rvalid_i(1'b1), .m_rready_o(b_rready),
    .m_awaddr_o(b_awaddr), .m_awvalid_o(b_awvalid), .m_awready_i(1'b1),
    .m_wdata_o(b_wdata), .m_wstrb_o(b_wstrb), .m_wvalid_o(b_wvalid), .m_wready_i(1'b1),
    .m_bresp_i(2'b00), .m_bvalid_i(1'b1), .m_bready_o(b_bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model for instance A ----------------
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  int          s_aw_lat, s_w_lat;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [31:0] cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  int          aw_hs_n, w_hs_n;

  assign a_arready = s_arready;
  assign a_awready = a_awvalid && (aw_cnt >= s_aw_lat);
  assign a_wready  = a_wvalid && (w_cnt >= s_w_lat);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      a_rresp  <= 2'b00;
    end else if (a_arvalid && a_arready) begin
      a_rvalid <= 1'b1;
      a_rdata  <= s_rdata;
      a_rresp  <= s_rresp;
    end else if (a_rvalid && a_rready) begin
      a_rvalid <= 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0;
      w_cnt  <= 0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      a_bvalid <= 1'b0;
      a_bresp  <= 2'b00;
    end else begin
      if (a_awvalid && a_awready) begin
        aw_cnt     <= 0;
        cap_awaddr <= a_awaddr;
        aw_hs_n    <= aw_hs_n + 1;
      end else if (a_awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (a_wvalid && a_wready) begin
        w_cnt     <= 0;
        cap_wdata <= a_wdata;
        cap_wstrb <= a_wstrb;
        w_hs_n    <= w_hs_n + 1;
      end else if (a_wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if ((aw_got || (a_awvalid && a_awready)) && (w_got || (a_wvalid && a_wready))) begin
        a_bvalid <= 1'b1;
        a_bresp  <= s_bresp;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        aw_got <= aw_got || (a_awvalid && a_awready);
        w_got  <= w_got || (a_wvalid && a_wready);
        if (a_bvalid && a_bready) a_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  int          a_acc_cyc, a_ar_rise_cyc, a_ar_rise_n, a_ar_hs_cyc, a_rr_rise_cyc;
  int          a_resp_n, a_resp_cyc;
  logic [31:0] a_resp_data_cap, a_araddr_cap;
  logic        a_resp_err_cap, a_arv_prev, a_rr_prev;

  always @(negedge clk) begin
    a_arv_prev <= a_arvalid;
    a_rr_prev  <= a_rready;
    if (rst_n) begin
      if (a_req_valid && a_req_ready) a_acc_cyc <= cyc;
      if (a_arvalid && !a_arv_prev) begin
        a_ar_rise_cyc <= cyc;
        a_ar_rise_n   <= a_ar_rise_n + 1;
      end
      if (a_arvalid && a_arready) begin
        a_ar_hs_cyc  <= cyc;
        a_araddr_cap <= a_araddr;
      end
      if (a_rready && !a_rr_prev) a_rr_rise_cyc <= cyc;
      if (a_resp_valid) begin
        a_resp_n        <= a_resp_n + 1;
        a_resp_cyc      <= cyc;
        a_resp_data_cap <= a_resp_rdata;
        a_resp_err_cap  <= a_resp_err;
      end
    end
  end

  int          b_acc_n, b_resp_n;
  int          b_acc_cyc [4];
  int          b_resp_cyc [4];
  logic [31:0] b_resp_data [4];
  logic        b_resp_errs [4];

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_req_valid && b_req_ready && b_acc_n < 4) begin
        b_acc_cyc[b_acc_n] <= cyc;
        b_acc_n <= b_acc_n + 1;
      end
      if (b_resp_valid && b_resp_n < 4) begin
        b_resp_cyc[b_resp_n]  <= cyc;
        b_resp_data[b_resp_n] <= b_resp_rdata;
        b_resp_errs[b_resp_n] <= b_resp_err;
        b_resp_n <= b_resp_n + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_a(input logic wen, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    while (!a_req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    a_req_wen      = wen;
    a_req_size     = sz;
    a_req_unsigned = uns;
    a_req_addr     = addr;
    a_req_wdata    = wd;
    a_req_valid    = 1'b1;
    @(posedge clk); #1;
    a_req_valid    = 1'b0;
    a_req_addr     = 32'h0;
    a_req_wdata    = 32'h0;
  endtask

  task automatic wait_resp_a(input string tag, input int target);
    int n = 0;
    while (a_resp_n < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 64'(a_resp_n), 64'(target));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    int ar_n0, resp0, aw0, w0;
    total = 0; bad = 0; cyc = 0;
    a_req_valid = 0; a_req_wen = 0; a_req_size = 0; a_req_unsigned = 0;
    a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_wen = 0; b_req_size = 0; b_req_unsigned = 0;
    b_req_addr = 0; b_req_wdata = 0;
    s_arready = 1; s_rdata = 0; s_rresp = 0; s_bresp = 0; s_aw_lat = 0; s_w_lat = 0;
    aw_hs_n = 0; w_hs_n = 0; a_ar_rise_n = 0; a_resp_n = 0; b_acc_n = 0; b_resp_n = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(a_req_ready), 64'd1);
    chk("rst_valids", 64'({a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready}), 64'd0);
    chk("rst_resp", 64'({a_resp_valid, a_resp_err, a_resp_rdata}), 64'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // lw 0x80000004: ARVALID after accept cycle + entry cycle + 3; RREADY 1 + 7 after handshake cycle
    s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
    req_a(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0);
    wait_resp_a("lw_resp_cnt", 1);
    chk("lw_ar_delay", 64'(a_ar_rise_cyc - a_acc_cyc), 64'd4);
    chk("lw_r_delay", 64'(a_rr_rise_cyc - a_ar_hs_cyc), 64'd8);
    chk("lw_araddr", 64'(a_araddr_cap), 64'h8000_0004);
    chk("lw_rdata", 64'(a_resp_data_cap), 64'hDEAD_BEEF);
    chk("lw_err", 64'(a_resp_err_cap), 64'd0);

    s_rdata = 32'h80FF_FFFF;
    req_a(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0);
    wait_resp_a("lb_resp_cnt", 2);
    chk("lb_rdata", 64'(a_resp_data_cap), 64'hFFFF_FF80);
    chk("lb_araddr", 64'(a_araddr_cap), 64'h8000_0000);

    req_a(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0);
    wait_resp_a("lbu_resp_cnt", 3);
    chk("lbu_rdata", 64'(a_resp_data_cap), 64'h0000_0080);

    s_rdata = 32'h1234_ABCD;
    req_a(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0);
    wait_resp_a("lh_resp_cnt", 4);
    chk("lh_rdata", 64'(a_resp_data_cap), 64'h0000_1234);

    // sh with AWREADY two cycles ahead of WREADY
    s_aw_lat = 0; s_w_lat = 2; aw0 = aw_hs_n; w0 = w_hs_n;
    req_a(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_BEEF);
    wait_resp_a("sh_resp_cnt", 5);
    chk("sh_wdata", 64'(cap_wdata), 64'hBEEF_0000);
    chk("sh_wstrb", 64'(cap_wstrb), 64'hC);
    chk("sh_awaddr", 64'(cap_awaddr), 64'h8000_0000);
    chk("sh_err", 64'(a_resp_err_cap), 64'd0);
    chk("sh_rdata_zero", 64'(a_resp_data_cap), 64'd0);
    repeat (4) @(posedge clk);
    chk("sh_single_resp", 64'(a_resp_n), 64'd5);
    chk("sh_aw_hs_once", 64'(aw_hs_n - aw0), 64'd1);
    chk("sh_w_hs_once", 64'(w_hs_n - w0), 64'd1);

    s_w_lat = 0;
    req_a(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00AB);
    wait_resp_a("sb_resp_cnt", 6);
    chk("sb_wdata", 64'(cap_wdata), 64'h0000_AB00);
    chk("sb_wstrb", 64'(cap_wstrb), 64'h2);

    // misaligned lw: response in the cycle after accept, no AR
    ar_n0 = a_ar_rise_n;
    req_a(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0);
    wait_resp_a("mis_resp_cnt", 7);
    chk("mis_latency", 64'(a_resp_cyc - a_acc_cyc), 64'd1);
    chk("mis_err", 64'(a_resp_err_cap), 64'd1);
    chk("mis_rdata", 64'(a_resp_data_cap), 64'd0);
    repeat (3) @(posedge clk);
    chk("mis_no_ar", 64'(a_ar_rise_n), 64'(ar_n0));

    // SLVERR on a load
    s_rdata = 32'h5555_5555; s_rresp = 2'b10;
    req_a(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0);
    wait_resp_a("slverr_resp_cnt", 8);
    chk("slverr_err", 64'(a_resp_err_cap), 64'd1);
    chk("slverr_rdata", 64'(a_resp_data_cap), 64'd0);
    s_rresp = 2'b00;

    // reset while ARVALID is held high by a stalled slave
    s_arready = 0; resp0 = a_resp_n;
    req_a(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0);
    n = 0;
    while (!a_arvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstmid_arvalid_seen", 64'(a_arvalid), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rstmid_valids", 64'({a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready, a_resp_valid}), 64'd0);
    s_arready = 1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("rstmid_req_ready", 64'(a_req_ready), 64'd1);
    repeat (12) @(posedge clk);
    chk("rstmid_no_resp", 64'(a_resp_n), 64'(resp0));

    // zero-delay instance: back-to-back lw then sw, 4 cycles accept..resp inclusive
    @(posedge clk); #1;
    b_req_wen = 0; b_req_size = 2'd2; b_req_addr = 32'h0000_0100; b_req_wdata = 0;
    b_req_valid = 1;
    @(posedge clk); #1;
    b_req_wen = 1; b_req_addr = 32'h0000_0104; b_req_wdata = 32'h1122_3344;
    n = 0;
    while (b_acc_n < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 b_req_valid = 0;
    n = 0;
    while (b_resp_n < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("b2b_resp_cnt", 64'(b_resp_n), 64'd2);
    chk("b2b_lw_latency", 64'(b_resp_cyc[0] - b_acc_cyc[0]), 64'd3);
    chk("b2b_sw_latency", 64'(b_resp_cyc[1] - b_acc_cyc[1]), 64'd3);
    chk("b2b_gap", 64'(b_acc_cyc[1] - b_resp_cyc[0]), 64'd1);
    chk("b2b_lw_rdata", 64'(b_resp_data[0]), 64'hCAFE_F00D);
    chk("b2b_sw_rdata", 64'(b_resp_data[1]), 64'd0);
    chk("b2b_errs", 64'({b_resp_errs[0], b_resp_errs[1]}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
